// File: rtl/resource_requester_pkg.sv
// -----------------------------------------------------------------------------
// resource_requester_pkg
//   Shared widths, the resource's response timing and the requester state
//   encoding used by resource_requester and its testbench.
// -----------------------------------------------------------------------------
package resource_requester_pkg;

    localparam int ADDRESS_WIDTH  = 8;
    localparam int ID_WIDTH       = 4;
    localparam int DATA_WIDTH     = 16;
    localparam int RESOURCE_DELAY = 4;
    localparam int RSP_WINDOW     = 16;

    typedef enum logic [2:0] {
        REQ_ST_IDLE  = 3'd0,
        REQ_ST_ISSUE = 3'd1,
        REQ_ST_WAIT  = 3'd2,
        REQ_ST_RESP  = 3'd3,
        REQ_ST_DRAIN = 3'd4
    } req_state_t;

endpackage

// File: rtl/resource_timeout_timer.sv
// -----------------------------------------------------------------------------
// resource_timeout_timer
//   Down-counter with terminal-count compare. clear reloads TIMEOUT_CYCLES-1,
//   enable decrements (saturating at zero). expired is high while enabled at
//   terminal count, i.e. on the TIMEOUT_CYCLES-th enabled cycle after clear.
// Ports
//   clk, reset_n : clock, async active-low reset
//   clear        : reload the counter
//   enable       : count this cycle
//   expired      : terminal count reached while enabled
// -----------------------------------------------------------------------------
module resource_timeout_timer #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int TO_WIDTH       = 7
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [TO_WIDTH-1:0] LOAD_VALUE = TO_WIDTH'(TIMEOUT_CYCLES - 1);

    logic [TO_WIDTH-1:0] count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= LOAD_VALUE;
        end else if (clear) begin
            count <= LOAD_VALUE;
        end else if (enable && (count != '0)) begin
            count <= count - TO_WIDTH'(1);
        end
    end

    assign expired = enable && (count == '0);

endmodule

// File: rtl/resource_requester.sv
// -----------------------------------------------------------------------------
// resource_requester
//   Initiator side of the shared-resource interface. Takes one address from
//   upstream, tags it, issues it to the resource, holds the matching response
//   until upstream takes it, then waits out the resource's response window.
//   One request outstanding at a time; supports flush and timeout.
// Ports
//   clk, reset_n                 : clock, async active-low reset
//   req_valid/req_address/req_ready : upstream request handshake
//   flush                        : cancel the current transaction
//   rsp_valid/rsp_data/rsp_id/rsp_ready : response held for upstream
//   err_timeout                  : one-cycle pulse when a request is abandoned
//   res_address/res_id/res_valid : request towards the resource
//   res_data/res_rsp_id/res_rsp_valid/res_ready : from the resource
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | ready for a new request
// ISSUE | res_valid high for this one cycle, timeout counter reloaded
// WAIT  | waiting for a response with our tag, or timeout
// RESP  | response held until upstream takes it (or flush drops it)
// DRAIN | waiting for the resource's response window to close
// -----------------------------------------------------------------------------
module resource_requester
    import resource_requester_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int TO_WIDTH       = 7
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     req_valid,
    input  logic [ADDRESS_WIDTH-1:0] req_address,
    output logic                     req_ready,
    input  logic                     flush,
    output logic                     rsp_valid,
    output logic [DATA_WIDTH-1:0]    rsp_data,
    output logic [ID_WIDTH-1:0]      rsp_id,
    input  logic                     rsp_ready,
    output logic                     err_timeout,
    output logic [ADDRESS_WIDTH-1:0] res_address,
    output logic [ID_WIDTH-1:0]      res_id,
    output logic                     res_valid,
    input  logic [DATA_WIDTH-1:0]    res_data,
    input  logic [ID_WIDTH-1:0]      res_rsp_id,
    input  logic                     res_rsp_valid,
    input  logic                     res_ready
);

    req_state_t          state;
    logic [ID_WIDTH-1:0] next_tag;
    logic                cancel;
    logic                timer_clear;
    logic                timer_enable;
    logic                timer_expired;
    logic                rsp_match;

    // The resource ignores in_valid during its response window even though
    // out_ready stays high, so a new request must also wait for that window.
    assign req_ready    = (state == REQ_ST_IDLE) && res_ready && !res_rsp_valid && !flush;
    assign rsp_match    = res_rsp_valid && (res_rsp_id == res_id);
    assign timer_clear  = (state == REQ_ST_ISSUE);
    assign timer_enable = (state == REQ_ST_WAIT);

    resource_timeout_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TO_WIDTH       (TO_WIDTH)
    ) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (timer_clear),
        .enable  (timer_enable),
        .expired (timer_expired)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= REQ_ST_IDLE;
            next_tag    <= '0;
            cancel      <= 1'b0;
            res_valid   <= 1'b0;
            res_address <= '0;
            res_id      <= '0;
            rsp_valid   <= 1'b0;
            rsp_data    <= '0;
            rsp_id      <= '0;
            err_timeout <= 1'b0;
        end else begin
            err_timeout <= 1'b0;
            unique case (state)
                REQ_ST_IDLE: begin
                    if (req_valid && req_ready) begin
                        res_address <= req_address;
                        res_id      <= next_tag;
                        next_tag    <= next_tag + ID_WIDTH'(1);
                        res_valid   <= 1'b1;
                        state       <= REQ_ST_ISSUE;
                    end
                end
                REQ_ST_ISSUE: begin
                    res_valid <= 1'b0;
                    // A flush here still has to be remembered: the request
                    // has already reached the resource.
                    if (flush) begin
                        cancel <= 1'b1;
                    end
                    state <= REQ_ST_WAIT;
                end
                REQ_ST_WAIT: begin
                    // A match beats a same-cycle timeout; a same-cycle flush
                    // discards the response.
                    if (rsp_match) begin
                        if (cancel || flush) begin
                            state <= REQ_ST_DRAIN;
                        end else begin
                            rsp_data  <= res_data;
                            rsp_id    <= res_rsp_id;
                            rsp_valid <= 1'b1;
                            state     <= REQ_ST_RESP;
                        end
                    end else begin
                        if (flush) begin
                            cancel <= 1'b1;
                        end
                        if (timer_expired) begin
                            err_timeout <= 1'b1;
                            state       <= REQ_ST_DRAIN;
                        end
                    end
                end
                REQ_ST_RESP: begin
                    if (flush || rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= REQ_ST_DRAIN;
                    end
                end
                REQ_ST_DRAIN: begin
                    if (!res_rsp_valid && res_ready) begin
                        cancel <= 1'b0;
                        state  <= REQ_ST_IDLE;
                    end
                end
                default: state <= REQ_ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_resource_requester.sv
module tb_resource_requester;
    import resource_requester_pkg::*;

    localparam int TO  = 16;
    localparam int LAT = RESOURCE_DELAY + 3;

    logic                     clk = 1'b0;
    logic                     reset_n = 1'b1;
    logic                     req_valid = 1'b0;
    logic [ADDRESS_WIDTH-1:0] req_address = '0;
    logic                     req_ready;
    logic                     flush = 1'b0;
    logic                     rsp_valid;
    logic [DATA_WIDTH-1:0]    rsp_data;
    logic [ID_WIDTH-1:0]      rsp_id;
    logic                     rsp_ready = 1'b1;
    logic                     err_timeout;
    logic [ADDRESS_WIDTH-1:0] res_address;
    logic [ID_WIDTH-1:0]      res_id;
    logic                     res_valid;

    // behavioural shared_resource
    logic                  res_hold = 1'b0;
    logic                  m_valid, m_ready;
    logic [DATA_WIDTH-1:0] m_data;
    logic [ID_WIDTH-1:0]   m_id;
    int                    m_cnt, m_win;
    wire                   res_rst_n = reset_n & ~res_hold;

    always #5 clk = ~clk;

    resource_requester #(.TIMEOUT_CYCLES(TO), .TO_WIDTH(5)) dut (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_address(req_address),
        .req_ready(req_ready), .flush(flush), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .rsp_id(rsp_id), .rsp_ready(rsp_ready), .err_timeout(err_timeout),
        .res_address(res_address), .res_id(res_id), .res_valid(res_valid),
        .res_data(m_data), .res_rsp_id(m_id), .res_rsp_valid(m_valid), .res_ready(m_ready)
    );

    always @(posedge clk or negedge res_rst_n) begin
        if (!res_rst_n) begin
            m_valid <= 1'b0; m_ready <= 1'b1; m_data <= '0; m_id <= '0; m_cnt <= 0; m_win <= 0;
        end else if (m_valid) begin
            if (m_win == 1) m_valid <= 1'b0;
            m_win <= m_win - 1;
        end else if (m_cnt != 0) begin
            if (m_cnt == 1) begin
                m_valid <= 1'b1; m_ready <= 1'b1; m_win <= RSP_WINDOW;
            end
            m_cnt <= m_cnt - 1;
        end else if (res_valid && m_ready) begin
            m_ready <= 1'b0;
            m_cnt   <= RESOURCE_DELAY + 1;
            m_data  <= DATA_WIDTH'(32'(res_address) + 32'h200);
            m_id    <= res_id;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [DATA_WIDTH-1:0] data;
        logic [ID_WIDTH-1:0]   id;
        int                    acc;
    } exp_t;
    exp_t sb[$];

    int checks = 0;
    int failures = 0;
    int delivered = 0;
    int ndel = 0;
    logic [ID_WIDTH-1:0] exp_tag = '0;
    logic rsp_valid_d = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    // response scoreboard and window monitor
    always @(negedge clk) begin
        if (!reset_n) begin
            rsp_valid_d = 1'b0;
        end else begin
            if (rsp_valid) begin
                chk("rsp_expected", 32'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    chk("rsp_data", 32'(rsp_data), 32'(sb[0].data));
                    chk("rsp_id", 32'(rsp_id), 32'(sb[0].id));
                    if (!rsp_valid_d) chk("rsp_latency", 32'(cyc - sb[0].acc), LAT);
                    if (rsp_ready) begin
                        void'(sb.pop_front());
                        delivered++;
                    end
                end
            end
            if (m_valid) chk("req_ready_in_window", 32'(req_ready), 0);
            rsp_valid_d = rsp_valid;
        end
    end

    task automatic do_req(input logic [ADDRESS_WIDTH-1:0] a, input bit push, output int acc);
        bit got;
        got = 1'b0;
        acc = 0;
        req_address = a;
        req_valid   = 1'b1;
        for (int n = 0; n < 200 && !got; n++) begin
            @(negedge clk);
            if (req_ready) got = 1'b1;
        end
        chk("req_accept_wait", 32'(got), 1);
        if (got) begin
            @(posedge clk); #1;
            req_valid = 1'b0;
            acc = cyc;
            if (push) sb.push_back('{DATA_WIDTH'(32'(a) + 32'h200), exp_tag, cyc});
            chk("res_valid_pulse", 32'(res_valid), 1);
            chk("res_id", 32'(res_id), 32'(exp_tag));
            chk("res_address", 32'(res_address), 32'(a));
            exp_tag++;
            @(posedge clk); #1;
            chk("res_valid_drop", 32'(res_valid), 0);
        end else begin
            req_valid = 1'b0;
        end
    endtask

    task automatic wait_delivered(input int target);
        for (int n = 0; n < 400 && delivered < target; n++) begin
            @(posedge clk); #1;
        end
        chk("deliver_count", 32'(delivered), 32'(target));
    endtask

    initial begin
        int  acc;
        bit  seen;
        #1 reset_n = 1'b0;
        #2;
        chk("rst_res_valid", 32'(res_valid), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_err", 32'(err_timeout), 0);
        chk("rst_res_address", 32'(res_address), 0);
        chk("rst_res_id", 32'(res_id), 0);
        chk("rst_rsp_data", 32'(rsp_data), 0);
        chk("rst_rsp_id", 32'(rsp_id), 0);
        @(posedge clk); #1 reset_n = 1'b1;
        @(posedge clk); #1;

        // 1: single request
        do_req(8'h10, 1'b1, acc);
        ndel = 1; wait_delivered(ndel);

        // 2: back-to-back requests
        do_req(8'h01, 1'b1, acc);
        do_req(8'h02, 1'b1, acc);
        ndel = 3; wait_delivered(ndel);

        // 3: upstream back-pressure
        rsp_ready = 1'b0;
        do_req(8'h33, 1'b1, acc);
        for (int n = 0; n < 50 && !rsp_valid; n++) begin
            @(posedge clk); #1;
        end
        repeat (20) @(posedge clk);
        #1;
        chk("hold_rsp_valid", 32'(rsp_valid), 1);
        chk("hold_not_delivered", 32'(delivered), 3);
        rsp_ready = 1'b1;
        ndel = 4; wait_delivered(ndel);
        chk("hold_single_delivery", 32'(rsp_valid), 0);

        // 4: flush two cycles after accept
        do_req(8'h44, 1'b0, acc);
        flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (m_valid) seen = 1'b1;
            else if (seen) break;
        end
        chk("flush_window_seen", 32'(seen), 1);
        chk("flush_drain_hold", 32'(req_ready), 0);
        @(negedge clk);
        chk("flush_drain_release", 32'(req_ready), 1);
        chk("flush_no_delivery", 32'(delivered), 4);

        // 5: timeout with resource held in reset
        @(posedge clk); #1 res_hold = 1'b1;
        do_req(8'h55, 1'b0, acc);
        for (int n = 0; n < 60 && !err_timeout; n++) @(negedge clk);
        chk("timeout_cycle", 32'(cyc - acc), 32'(TO + 1));
        @(negedge clk);
        chk("timeout_single_pulse", 32'(err_timeout), 0);
        chk("timeout_back_idle", 32'(req_ready), 1);
        @(posedge clk); #1 res_hold = 1'b0;

        // 6: tag wrap, then reset mid-WAIT
        while (exp_tag != '1) begin
            do_req(8'($urandom_range(1, 255)), 1'b1, acc);
            ndel++; wait_delivered(ndel);
        end
        do_req(8'hF0, 1'b1, acc);
        do_req(8'h0F, 1'b1, acc);
        ndel += 2; wait_delivered(ndel);
        chk("wrap_last_id", 32'(rsp_id), 0);
        do_req(8'h5A, 1'b0, acc);
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_res_address", 32'(res_address), 0);
        chk("arst_res_id", 32'(res_id), 0);
        chk("arst_rsp_data", 32'(rsp_data), 0);
        chk("arst_rsp_id", 32'(rsp_id), 0);
        chk("arst_rsp_valid", 32'(rsp_valid), 0);
        chk("arst_res_valid", 32'(res_valid), 0);
        sb.delete();
        exp_tag = '0;
        @(posedge clk); #1 reset_n = 1'b1;
        do_req(8'h77, 1'b1, acc);
        ndel++; wait_delivered(ndel);
        chk("sb_empty", 32'(sb.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
